// File: rtl/bft_host_port_pkg.sv
// Shared BFT packet layout and credit constants for the host-side port.
package bft_host_port_pkg;

  localparam int PACKET_BITS        = 49;
  localparam int PAYLOAD_BITS       = 32;
  localparam int NUM_LEAF_BITS      = 5;
  localparam int NUM_PORT_BITS      = 4;
  localparam int NUM_ADDR_BITS      = 7;
  localparam int NUM_BRAM_ADDR_BITS = 7;
  localparam int RX_FIFO_DEPTH      = 16;

  localparam int VALID_BIT   = 48;
  localparam int LEAF_LSB    = 43;
  localparam int PORT_LSB    = 39;
  localparam int SEQ_LSB     = 32;
  localparam int PAYLOAD_LSB = 0;

  localparam int CTRL_PORT    = 0;
  localparam int INIT_CREDITS = 1 << NUM_BRAM_ADDR_BITS;

endpackage

// File: rtl/bft_host_port_rx_fifo.sv
// Synchronous FIFO for RX payloads; a push into a full FIFO is accepted when a pop happens the same cycle.
module bft_rx_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries data only; pointers alone define occupancy.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/bft_host_port.sv
// Host endpoint on the BFT: credit-controlled TX packetizer and FIFO-buffered RX extractor.
module bft_host_port
  import bft_host_port_pkg::*;
#(
  parameter int STAGES = 1
) (
  input  logic                          clk_bft,
  input  logic                          reset_bft_n,
  input  logic [NUM_LEAF_BITS-1:0]      dest_leaf,
  input  logic [NUM_PORT_BITS-1:0]      dest_port,
  input  logic [PAYLOAD_BITS-1:0]       din_user2port,
  input  logic                          vld_user2port,
  output logic                          ack_port2user,
  output logic [PACKET_BITS-1:0]        dout_port2bft,
  input  logic [PACKET_BITS-1:0]        din_bft2port,
  output logic [PAYLOAD_BITS-1:0]       dout_port2user,
  output logic                          vld_port2user,
  input  logic                          ack_user2port,
  output logic [NUM_BRAM_ADDR_BITS:0]   credits,
  output logic                          rx_overflow
);

  localparam int CRED_W = NUM_BRAM_ADDR_BITS + 1;
  localparam int SUM_W  = CRED_W + 2;
  localparam logic signed [SUM_W-1:0] CRED_MAX = SUM_W'(INIT_CREDITS);

  // Clamp the signed credit sum into [0, INIT_CREDITS].
  function automatic logic [CRED_W-1:0] sat_credit(input logic signed [SUM_W-1:0] sum);
    if (sum > CRED_MAX)
      return CRED_W'(INIT_CREDITS);
    else if (sum < 0)
      return '0;
    else
      return sum[CRED_W-1:0];
  endfunction

  logic [CRED_W-1:0]        credit_q;
  logic [NUM_ADDR_BITS-1:0] seq_q;
  logic [PACKET_BITS-1:0]   tx_pkt_p1;
  logic                     send;
  logic                     rx_vld;
  logic [NUM_PORT_BITS-1:0] rx_port;
  logic                     is_ctrl;
  logic                     is_data;
  logic [CRED_W-1:0]        upd;
  logic signed [SUM_W-1:0]  credit_sum;
  logic [PAYLOAD_BITS-1:0]  fifo_dout;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     pop_now;
  logic                     drop;
  logic                     unused_fields;

  assign send    = reset_bft_n && vld_user2port && (credit_q != '0);
  assign rx_vld  = din_bft2port[VALID_BIT];
  assign rx_port = din_bft2port[PORT_LSB +: NUM_PORT_BITS];
  assign is_ctrl = rx_vld && (rx_port == NUM_PORT_BITS'(CTRL_PORT));
  assign is_data = rx_vld && (rx_port != NUM_PORT_BITS'(CTRL_PORT));
  assign upd     = is_ctrl ? din_bft2port[PAYLOAD_LSB +: CRED_W] : '0;

  assign credit_sum = $signed({2'b00, credit_q}) + $signed({2'b00, upd})
                    - $signed({{(SUM_W-1){1'b0}}, send});

  assign unused_fields = ^{din_bft2port[LEAF_LSB +: NUM_LEAF_BITS],
                           din_bft2port[SEQ_LSB +: NUM_ADDR_BITS], STAGES[0]};

  // TX stage p0 -> p1: one packet per acknowledged word, idle bus otherwise.
  always_ff @(posedge clk_bft or negedge reset_bft_n) begin
    if (!reset_bft_n) begin
      tx_pkt_p1 <= '0;
      seq_q     <= '0;
      credit_q  <= CRED_W'(INIT_CREDITS);
    end else begin
      credit_q <= sat_credit(credit_sum);
      if (send) begin
        tx_pkt_p1 <= {1'b1, dest_leaf, dest_port, seq_q, din_user2port};
        seq_q     <= seq_q + 1'b1;
      end else begin
        tx_pkt_p1 <= '0;
      end
    end
  end

  assign ack_port2user = send;
  assign dout_port2bft = tx_pkt_p1;
  assign credits       = credit_q;

  bft_rx_fifo #(
    .DATA_W (PAYLOAD_BITS),
    .DEPTH  (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (clk_bft),
    .rst_n (reset_bft_n),
    .push  (is_data),
    .din   (din_bft2port[PAYLOAD_LSB +: PAYLOAD_BITS]),
    .pop   (ack_user2port),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign pop_now = ack_user2port && !fifo_empty;
  assign drop    = is_data && fifo_full && !pop_now;

  always_ff @(posedge clk_bft or negedge reset_bft_n) begin
    if (!reset_bft_n)
      rx_overflow <= 1'b0;
    else if (drop)
      rx_overflow <= 1'b1;
  end

  assign vld_port2user  = !fifo_empty;
  assign dout_port2user = fifo_empty ? '0 : fifo_dout;

endmodule
